pwm_softstart: RTL

Soft-start PWM generator for the regulator control path. Sits directly downstream of the slow-clock divider and consumes its single-cycle `slow_clk` pulse as `tick`, its only time base. It produces one PWM output whose duty moves toward a requested target by one count per PWM period. This gives a monotonic soft-start ramp and limits the slew of later duty changes.

---
 rtl/pwm_softstart.sv | 78 +++++++
 1 files changed

// File: rtl/pwm_softstart.sv
// Soft-start PWM: duty steps toward the clamped target once per period (direct load unless PWM_SOFTSTART_EN).
// Latency: all outputs registered; pwm_out follows cnt/duty_now by one clock, status flags by one clock after the wrapping tick.
// Backpressure: none; tick is the only time base and enable=0 clears the block on the next edge.
module pwm_softstart #(
  parameter int WIDTH  = 8,
  parameter int PERIOD = 200
) (
  input  logic             original_clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             enable,
  input  logic [WIDTH-1:0] duty_target,
  output logic             pwm_out,
  output logic [WIDTH-1:0] duty_now,
  output logic             ramp_done,
  output logic             period_start
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RAMP = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  localparam logic [WIDTH-1:0] PERIOD_V = WIDTH'(PERIOD);
  localparam logic [WIDTH-1:0] LAST_V   = WIDTH'(PERIOD - 1);
  localparam logic [WIDTH-1:0] ONE_V    = WIDTH'(1);

  logic [1:0]       state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] duty_step;
  logic             wrap;
  logic             clear_all;
  logic             at_target;

  assign tgt       = (duty_target > PERIOD_V) ? PERIOD_V : duty_target;
  assign wrap      = tick && (cnt >= LAST_V);
  assign clear_all = !reset || (state == IDLE) || !enable;
  assign at_target = (duty_step == tgt);

  // Duty value that will be applied at the next wrap.
  always_comb begin
    duty_step = duty_now;
`ifdef PWM_SOFTSTART_EN
    if (duty_now < tgt) begin
      duty_step = duty_now + ONE_V;
    end else if (duty_now > tgt) begin
      duty_step = duty_now - ONE_V;
    end
`else
    duty_step = tgt;
`endif
  end

  always_ff @(posedge original_clk) begin
    if (clear_all) begin
      // Reset, IDLE and a dropped enable all clear every register; only a
      // live IDLE with enable=1 leaves for RAMP.
      state        <= (reset && (state == IDLE) && enable) ? RAMP : IDLE;
      cnt          <= '0;
      duty_now     <= '0;
      pwm_out      <= 1'b0;
      ramp_done    <= 1'b0;
      period_start <= 1'b0;
    end else begin
      pwm_out      <= (cnt < duty_now);
      period_start <= wrap;
      if (wrap) begin
        cnt       <= '0;
        duty_now  <= duty_step;
        state     <= at_target ? RUN : RAMP;
        ramp_done <= at_target;
      end else if (tick) begin
        cnt <= cnt + ONE_V;
      end
    end
  end

endmodule
